// File: rtl/imem_pkg.sv
// imem_pkg: shared types and defaults for the instruction memory slice.
//   IMEM_INIT_WORD : fill value written into every word after reset (RV32I NOP)
//   fault_e        : fetch fault classification, bit0 = misaligned, bit1 = out of range
//   state_e        : fill/run controller states
//   classify_pc    : fault classification of a byte address against a word depth
package imem_pkg;

  localparam logic [31:0] IMEM_INIT_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_RANGE    = 2'd2,
    FAULT_BOTH     = 2'd3
  } fault_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic fault_e classify_pc(input logic [31:0] pc, input int unsigned depth);
    logic misalign;
    logic range_err;
    misalign  = |pc[1:0];
    // Full 32-bit compare: high address bits beyond the array index must not alias.
    range_err = ({2'b00, pc[31:2]} >= depth);
    return fault_e'({range_err, misalign});
  endfunction

endpackage

// File: rtl/imem_fetch_if.sv
// imem_fetch_if: program-load port, fetch request port and instruction output
// port of the instruction memory, bundled as one interface.
//   master : boot loader / fetch stage / decode side (drives requests, load writes, instr_ready)
//   slave  : imem_fetch (drives readiness, fetched instruction and fault fields)
interface imem_fetch_if #(
  parameter int unsigned AW = 8
) ();
  import imem_pkg::*;

  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;
  logic          prog_ready;

  logic          fetch_req;
  logic [31:0]   fetch_pc;
  logic          fetch_ready;

  logic          instr_valid;
  logic [31:0]   instr_code;
  logic [31:0]   instr_pc;
  logic          instr_fault;
  fault_e        fault_code;
  logic          instr_ready;

  logic          init_done;

  modport master (
    output prog_we, prog_addr, prog_data, fetch_req, fetch_pc, instr_ready,
    input  prog_ready, fetch_ready, instr_valid, instr_code, instr_pc,
           instr_fault, fault_code, init_done
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, fetch_req, fetch_pc, instr_ready,
    output prog_ready, fetch_ready, instr_valid, instr_code, instr_pc,
           instr_fault, fault_code, init_done
  );

endinterface

// File: rtl/imem_array.sv
// imem_array: DEPTH x 32 word storage, one synchronous write port and one
// synchronous read port. A read and write to the same word on the same edge
// returns the old contents. rd_data holds its value while rd_en is low.
//   clk            : clock
//   wr_en/addr/data: write port
//   rd_en/addr     : read port, rd_data registered
module imem_array #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/imem_fetch.sv
// imem_fetch: writable instruction memory with a registered fetch handshake.
// After reset the whole array is filled with INIT_WORD, then the load port
// and fetch port open. Fetches complete in one cycle into a single-entry
// output register with valid/ready flow control and fault reporting.
//   clk, reset : clock, synchronous active-high reset
//   bus        : imem_fetch_if slave (load port, fetch port, instruction output)
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | filling word[fill_cnt] with INIT_WORD, ports closed
// ST_RUN  | load port and fetch port active, init_done high
module imem_fetch
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] INIT_WORD = IMEM_INIT_WORD
) (
  input  logic      clk,
  input  logic      reset,
  imem_fetch_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] fill_cnt_q, fill_cnt_d;

  logic          run;
  logic          accept;
  fault_e        fault_d;

  logic          valid_q;
  logic [31:0]   pc_q;
  fault_e        fault_q;
  // Set when the output should show array data; cleared for faults and reset
  // so the output shows INIT_WORD without touching the array read register.
  logic          from_array_q;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [31:0]   rd_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      fill_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    case (state_q)
      ST_INIT: begin
        fill_cnt_d = fill_cnt_q + AW'(1);
        if (fill_cnt_q == AW'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN: ;
      default: state_d = ST_INIT;
    endcase
  end

  assign run             = (state_q == ST_RUN);
  assign bus.init_done   = run;
  assign bus.prog_ready  = run;
  assign bus.fetch_ready = run & (~valid_q | bus.instr_ready);
  assign accept          = bus.fetch_req & bus.fetch_ready;
  assign fault_d         = classify_pc(bus.fetch_pc, DEPTH);

  // Fill counter owns the write port during INIT, the load port during RUN.
  assign wr_en   = ~reset & (run ? bus.prog_we : 1'b1);
  assign wr_addr = run ? bus.prog_addr : fill_cnt_q;
  assign wr_data = run ? bus.prog_data : INIT_WORD;

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (accept),
    .rd_addr (bus.fetch_pc[AW+1:2]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      fault_q      <= FAULT_NONE;
      from_array_q <= 1'b0;
    end else if (accept) begin
      valid_q      <= 1'b1;
      pc_q         <= bus.fetch_pc;
      fault_q      <= fault_d;
      from_array_q <= (fault_d == FAULT_NONE);
    end else if (bus.instr_ready) begin
      valid_q      <= 1'b0;
    end
  end

  assign bus.instr_valid = valid_q;
  assign bus.instr_pc    = pc_q;
  assign bus.fault_code  = fault_q;
  assign bus.instr_fault = (fault_q != FAULT_NONE);
  assign bus.instr_code  = from_array_q ? rd_data : INIT_WORD;

endmodule

// File: tb/tb_imem_fetch.sv
module tb_imem_fetch;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic clk = 1'b0;
  logic reset;

  int n_pass  = 0;
  int n_total = 0;

  imem_fetch_if #(.AW(AW)) bus ();

  imem_fetch #(
    .DEPTH     (DEPTH),
    .INIT_WORD (32'h0000_0013)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] code,
                         input logic [31:0] pc, input logic flt, input logic [1:0] fc);
    chk({tag, ".valid"}, {31'd0, bus.instr_valid}, {31'd0, v});
    chk({tag, ".code"},  bus.instr_code, code);
    chk({tag, ".pc"},    bus.instr_pc, pc);
    chk({tag, ".fault"}, {31'd0, bus.instr_fault}, {31'd0, flt});
    chk({tag, ".fcode"}, {30'd0, bus.fault_code}, {30'd0, fc});
  endtask

  initial begin
    logic [31:0] prog [4];
    prog[0] = 32'h0094_0333;
    prog[1] = 32'h8001_00b3;
    prog[2] = 32'h0020_9133;
    prog[3] = 32'h00c5_4ab3;

    reset           = 1'b1;
    bus.prog_we     = 1'b0;
    bus.prog_addr   = '0;
    bus.prog_data   = '0;
    bus.fetch_req   = 1'b0;
    bus.fetch_pc    = '0;
    bus.instr_ready = 1'b1;

    // Reset held for three edges.
    step(); step(); step();
    chk_out("rst", 1'b0, 32'h13, 32'h0, 1'b0, 2'd0);
    chk("rst.prog_ready",  {31'd0, bus.prog_ready},  32'd0);
    chk("rst.fetch_ready", {31'd0, bus.fetch_ready}, 32'd0);
    chk("rst.init_done",   {31'd0, bus.init_done},   32'd0);

    // Release; requests and loads during INIT must be ignored.
    reset         = 1'b0;
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 32'h3C;
    bus.prog_we   = 1'b1;
    bus.prog_addr = 4'd7;
    bus.prog_data = 32'hDEAD_BEEF;
    for (int i = 1; i <= 15; i++) step();
    chk("init15.init_done",   {31'd0, bus.init_done},   32'd0);
    chk("init15.fetch_ready", {31'd0, bus.fetch_ready}, 32'd0);
    chk("init15.prog_ready",  {31'd0, bus.prog_ready},  32'd0);
    chk("init15.valid",       {31'd0, bus.instr_valid}, 32'd0);
    step();
    bus.prog_we = 1'b0;
    chk("init16.init_done",   {31'd0, bus.init_done},   32'd1);
    chk("init16.fetch_ready", {31'd0, bus.fetch_ready}, 32'd1);
    chk("init16.prog_ready",  {31'd0, bus.prog_ready},  32'd1);
    step();
    chk_out("fetch3c", 1'b1, 32'h13, 32'h3C, 1'b0, 2'd0);

    // Load words 0-3; the pending output is consumed on the first edge.
    bus.fetch_req = 1'b0;
    bus.prog_we   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.prog_addr = AW'(i);
      bus.prog_data = prog[i];
      step();
    end
    bus.prog_we = 1'b0;
    chk("load.valid_drop", {31'd0, bus.instr_valid}, 32'd0);

    // Back-to-back stream.
    bus.fetch_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.fetch_pc = 32'(i * 4);
      step();
      chk_out($sformatf("stream%0d", i), 1'b1, prog[i], 32'(i * 4), 1'b0, 2'd0);
    end
    bus.fetch_pc = 32'h1C;
    step();
    chk_out("word7", 1'b1, 32'h13, 32'h1C, 1'b0, 2'd0);
    bus.fetch_req = 1'b0;
    step();
    chk("stream.idle", {31'd0, bus.instr_valid}, 32'd0);

    // Backpressure.
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 32'h0;
    step();
    chk_out("bp.first", 1'b1, prog[0], 32'h0, 1'b0, 2'd0);
    bus.instr_ready = 1'b0;
    bus.fetch_pc    = 32'h4;
    #1;
    chk("bp.fetch_ready0", {31'd0, bus.fetch_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out($sformatf("bp.hold%0d", i), 1'b1, prog[0], 32'h0, 1'b0, 2'd0);
      chk($sformatf("bp.stall%0d", i), {31'd0, bus.fetch_ready}, 32'd0);
    end
    bus.instr_ready = 1'b1;
    #1;
    chk("bp.fetch_ready1", {31'd0, bus.fetch_ready}, 32'd1);
    step();
    chk_out("bp.next", 1'b1, prog[1], 32'h4, 1'b0, 2'd0);
    bus.fetch_pc = 32'h8;
    step();
    chk_out("bp.after", 1'b1, prog[2], 32'h8, 1'b0, 2'd0);

    // Faults.
    bus.fetch_pc = 32'h02;
    step();
    chk_out("flt.misalign", 1'b1, 32'h13, 32'h02, 1'b1, 2'd1);
    bus.fetch_pc = 32'h40;
    step();
    chk_out("flt.range", 1'b1, 32'h13, 32'h40, 1'b1, 2'd2);
    bus.fetch_pc = 32'h41;
    step();
    chk_out("flt.both", 1'b1, 32'h13, 32'h41, 1'b1, 2'd3);
    bus.fetch_pc = 32'h8000_0004;
    step();
    chk_out("flt.highbits", 1'b1, 32'h13, 32'h8000_0004, 1'b1, 2'd2);
    bus.fetch_pc = 32'hC;
    step();
    chk_out("flt.clear", 1'b1, prog[3], 32'hC, 1'b0, 2'd0);

    // Write/read collision on word 5.
    bus.fetch_req = 1'b0;
    bus.prog_we   = 1'b1;
    bus.prog_addr = 4'd5;
    bus.prog_data = 32'h1234_5237;
    step();
    bus.prog_data = 32'h0000_80EF;
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 32'h14;
    step();
    bus.prog_we = 1'b0;
    chk_out("coll.old", 1'b1, 32'h1234_5237, 32'h14, 1'b0, 2'd0);
    step();
    chk_out("coll.new", 1'b1, 32'h0000_80EF, 32'h14, 1'b0, 2'd0);

    // Mid-run reset with a valid output pending.
    bus.fetch_req   = 1'b0;
    bus.instr_ready = 1'b0;
    reset           = 1'b1;
    step();
    chk_out("mrst", 1'b0, 32'h13, 32'h0, 1'b0, 2'd0);
    chk("mrst.init_done", {31'd0, bus.init_done}, 32'd0);
    reset           = 1'b0;
    bus.instr_ready = 1'b1;
    for (int i = 1; i <= 15; i++) step();
    chk("mrst.init15", {31'd0, bus.init_done}, 32'd0);
    step();
    chk("mrst.init16", {31'd0, bus.init_done}, 32'd1);
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 32'h14;
    step();
    chk_out("mrst.word5", 1'b1, 32'h13, 32'h14, 1'b0, 2'd0);
    bus.fetch_req = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
